// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage plus the IF/ID pipeline register. A single
//   request is issued to instruction memory at a time over a req/ready
//   handshake. A one-entry skid buffer catches a response that arrives while
//   ID is stalled. The DRAIN state lets a redirect wait out a response that
//   is already in flight.
//
// Ports
//   Clk, Reset          clock, synchronous active-high reset
//   Stall               ID stalled: hold the IF/ID register
//   Flush, NewPC        discard pipeline contents, redirect to NewPC
//   BrTaken, BrAddr     decoder redirect for the instruction in IF/ID
//   InsnReq, InsnAddr   instruction memory request / word address
//   InsnRdy, InsnRdData memory response valid / instruction word
//   IFPC, IFInsn, IFEn  IF/ID register contents
//   Busy                request waiting on memory (InsnReq & ~InsnRdy)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [29:0] RESET_VECTOR = 30'h0,
  parameter logic [31:0] NOP_INSN     = 32'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [29:0] NewPC,
  input  logic        BrTaken,
  input  logic [29:0] BrAddr,
  output logic        InsnReq,
  output logic [29:0] InsnAddr,
  input  logic        InsnRdy,
  input  logic [31:0] InsnRdData,
  output logic [29:0] IFPC,
  output logic [31:0] IFInsn,
  output logic        IFEn,
  output logic        Busy
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state_q,    state_d;
  logic [29:0] pc_q,       pc_d;
  logic [29:0] req_addr_q, req_addr_d;
  logic [29:0] skid_pc_q,  skid_pc_d;
  logic [31:0] skid_insn_q, skid_insn_d;
  logic [29:0] if_pc_q,    if_pc_d;
  logic [31:0] if_insn_q,  if_insn_d;
  logic        if_en_q,    if_en_d;
  logic        br_take;

  // A branch only counts when it belongs to a valid instruction that is
  // actually leaving ID this cycle; a stalled branch is re-presented later.
  assign br_take = BrTaken & if_en_q & ~Stall & ~Flush;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    skid_pc_d   = skid_pc_q;
    skid_insn_d = skid_insn_q;
    if_pc_d     = if_pc_q;
    if_insn_d   = if_insn_q;
    if_en_d     = if_en_q;

    case (state_q)
      S_FETCH: begin
        if (Flush) begin
          pc_d      = NewPC;
          if_en_d   = 1'b0;
          if_insn_d = NOP_INSN;
          // An unanswered request must complete before the new address goes out.
          if (InsnRdy) req_addr_d = NewPC;
          else         state_d    = S_DRAIN;
        end else if (Stall) begin
          if (InsnRdy) begin
            skid_pc_d   = req_addr_q;
            skid_insn_d = InsnRdData;
            state_d     = S_HOLD;
          end
        end else if (br_take) begin
          pc_d      = BrAddr;
          if_en_d   = 1'b0;
          if_insn_d = NOP_INSN;
          if (InsnRdy) req_addr_d = BrAddr;
          else         state_d    = S_DRAIN;
        end else if (InsnRdy) begin
          if_pc_d    = req_addr_q;
          if_insn_d  = InsnRdData;
          if_en_d    = 1'b1;
          pc_d       = req_addr_q + 30'd1;
          req_addr_d = req_addr_q + 30'd1;
        end else begin
          if_en_d   = 1'b0;
          if_insn_d = NOP_INSN;
        end
      end

      S_HOLD: begin
        // Skid contents are valid exactly while in HOLD.
        if (Flush) begin
          pc_d       = NewPC;
          req_addr_d = NewPC;
          if_en_d    = 1'b0;
          if_insn_d  = NOP_INSN;
          state_d    = S_FETCH;
        end else if (Stall) begin
          state_d = S_HOLD;
        end else if (br_take) begin
          pc_d       = BrAddr;
          req_addr_d = BrAddr;
          if_en_d    = 1'b0;
          if_insn_d  = NOP_INSN;
          state_d    = S_FETCH;
        end else begin
          if_pc_d    = skid_pc_q;
          if_insn_d  = skid_insn_q;
          if_en_d    = 1'b1;
          pc_d       = skid_pc_q + 30'd1;
          req_addr_d = skid_pc_q + 30'd1;
          state_d    = S_FETCH;
        end
      end

      S_DRAIN: begin
        // Old request stays on the bus until answered; its data is dropped.
        if_en_d   = 1'b0;
        if_insn_d = NOP_INSN;
        if (Flush) pc_d = NewPC;
        if (InsnRdy) begin
          req_addr_d = Flush ? NewPC : pc_q;
          state_d    = S_FETCH;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_VECTOR;
      req_addr_q  <= RESET_VECTOR;
      skid_pc_q   <= 30'h0;
      skid_insn_q <= NOP_INSN;
      if_pc_q     <= 30'h0;
      if_insn_q   <= NOP_INSN;
      if_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      skid_pc_q   <= skid_pc_d;
      skid_insn_q <= skid_insn_d;
      if_pc_q     <= if_pc_d;
      if_insn_q   <= if_insn_d;
      if_en_q     <= if_en_d;
    end
  end

  assign InsnReq  = (state_q != S_HOLD);
  assign InsnAddr = req_addr_q;
  assign Busy     = InsnReq & ~InsnRdy;
  assign IFPC     = if_pc_q;
  assign IFInsn   = if_insn_q;
  assign IFEn     = if_en_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Memory returns addr | 0xA0000000; the
// bench drives InsnRdy per cycle to model wait states.
module tb_if_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, BrTaken, InsnRdy;
  logic [29:0] NewPC, BrAddr;
  logic        InsnReq, IFEn, Busy;
  logic [29:0] InsnAddr, IFPC;
  logic [31:0] InsnRdData, IFInsn;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  assign InsnRdData = 32'hA000_0000 | {2'b00, InsnAddr};

  if_fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .NewPC(NewPC),
    .BrTaken(BrTaken), .BrAddr(BrAddr), .InsnReq(InsnReq), .InsnAddr(InsnAddr),
    .InsnRdy(InsnRdy), .InsnRdData(InsnRdData), .IFPC(IFPC), .IFInsn(IFInsn),
    .IFEn(IFEn), .Busy(Busy)
  );

  typedef struct {
    logic        rst, s, f;
    logic [29:0] np;
    logic        b;
    logic [29:0] ba;
    logic        y;
    logic        busy;   // expected Busy with these inputs, before the edge
    logic        req;    // expected after the edge
    logic [29:0] addr;
    logic        en;
    logic [29:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic s, logic f, logic [29:0] np,
                              logic b, logic [29:0] ba, logic y, logic busy,
                              logic req, logic [29:0] addr, logic en,
                              logic [29:0] pc);
    vec_t v;
    v.rst = rst; v.s = s; v.f = f; v.np = np; v.b = b; v.ba = ba; v.y = y;
    v.busy = busy; v.req = req; v.addr = addr; v.en = en; v.pc = pc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge: drive, check Busy, clock, check registers.
  task automatic run_vec(int idx, vec_t v);
    logic [31:0] exp_insn;
    Reset = v.rst; Stall = v.s; Flush = v.f; NewPC = v.np;
    BrTaken = v.b; BrAddr = v.ba; InsnRdy = v.y;
    #1;
    chk($sformatf("v%0d Busy", idx), {31'b0, Busy}, {31'b0, v.busy});
    @(posedge Clk); #1;
    exp_insn = v.en ? (32'hA000_0000 | {2'b00, v.pc}) : 32'h0;
    chk($sformatf("v%0d InsnReq", idx), {31'b0, InsnReq}, {31'b0, v.req});
    chk($sformatf("v%0d InsnAddr", idx), {2'b0, InsnAddr}, {2'b0, v.addr});
    chk($sformatf("v%0d IFEn", idx), {31'b0, IFEn}, {31'b0, v.en});
    chk($sformatf("v%0d IFInsn", idx), IFInsn, exp_insn);
    if (v.en) chk($sformatf("v%0d IFPC", idx), {2'b0, IFPC}, {2'b0, v.pc});
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; BrTaken = 1'b0; InsnRdy = 1'b0;
    NewPC = 30'h0; BrAddr = 30'h0;

    //          rst s f  np           b  ba        y  busy req addr         en pc
    // zero-wait sequential fetch
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h1,       1, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h2,       1, 30'h1));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h3,       1, 30'h2));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h4,       1, 30'h3));
    // two wait states on addr 4
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   0, 1,  1, 30'h4,       0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   0, 1,  1, 30'h4,       0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h5,       1, 30'h4));
    // stall 3 cycles as addr 5 returns -> HOLD, then release
    tbl.push_back(mk(0,1,0,30'h0,        0,30'h0,   1, 0,  0, 30'h5,       1, 30'h4));
    tbl.push_back(mk(0,1,0,30'h0,        0,30'h0,   0, 0,  0, 30'h5,       1, 30'h4));
    tbl.push_back(mk(0,1,0,30'h0,        0,30'h0,   0, 0,  0, 30'h5,       1, 30'h4));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   0, 0,  1, 30'h6,       1, 30'h5));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h7,       1, 30'h6));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h8,       1, 30'h7));
    // taken branch with IFPC=7: instruction 8 dropped
    tbl.push_back(mk(0,0,0,30'h0,        1,30'h100, 1, 0,  1, 30'h100,     0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h101,     1, 30'h100));
    // branch during stall is ignored
    tbl.push_back(mk(0,1,0,30'h0,        1,30'h200, 0, 1,  1, 30'h101,     1, 30'h100));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h102,     1, 30'h101));
    // flush to 0x12, request waits, flush to 0x40 -> DRAIN
    tbl.push_back(mk(0,0,1,30'h12,       0,30'h0,   1, 0,  1, 30'h12,      0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   0, 1,  1, 30'h12,      0, 30'h0));
    tbl.push_back(mk(0,0,1,30'h40,       0,30'h0,   0, 1,  1, 30'h12,      0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   0, 1,  1, 30'h12,      0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h40,      0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h41,      1, 30'h40));
    // flush + stall flushes; PC wrap at 3FFFFFFF
    tbl.push_back(mk(0,1,1,30'h3FFFFFFF, 0,30'h0,   1, 0,  1, 30'h3FFFFFFF,0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h0,       1, 30'h3FFFFFFF));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h1,       1, 30'h0));
    // flush into DRAIN, then flush again on the cycle the data returns
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   0, 1,  1, 30'h1,       0, 30'h0));
    tbl.push_back(mk(0,0,1,30'h50,       0,30'h0,   0, 1,  1, 30'h1,       0, 30'h0));
    tbl.push_back(mk(0,0,1,30'h60,       0,30'h0,   1, 0,  1, 30'h60,      0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h61,      1, 30'h60));
    // branch with an outstanding request -> DRAIN
    tbl.push_back(mk(0,0,0,30'h0,        1,30'h20,  0, 1,  1, 30'h61,      0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h20,      0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h21,      1, 30'h20));
    // branch out of HOLD discards the skid entry
    tbl.push_back(mk(0,1,0,30'h0,        0,30'h0,   1, 0,  0, 30'h21,      1, 30'h20));
    tbl.push_back(mk(0,0,0,30'h0,        1,30'h30,  0, 0,  1, 30'h30,      0, 30'h0));
    tbl.push_back(mk(0,0,0,30'h0,        0,30'h0,   1, 0,  1, 30'h31,      1, 30'h30));

    // reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("reset InsnReq", {31'b0, InsnReq}, 32'h1);
    chk("reset InsnAddr", {2'b0, InsnAddr}, 32'h0);
    chk("reset IFPC", {2'b0, IFPC}, 32'h0);
    chk("reset IFInsn", IFInsn, 32'h0);
    chk("reset IFEn", {31'b0, IFEn}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // reset asserted mid-DRAIN
    run_vec(100, mk(0,0,0,30'h0,  0,30'h0, 0, 1, 1, 30'h31, 0, 30'h0));
    run_vec(101, mk(0,0,1,30'h99, 0,30'h0, 0, 1, 1, 30'h31, 0, 30'h0));
    run_vec(102, mk(1,0,0,30'h0,  0,30'h0, 0, 1, 1, 30'h0,  0, 30'h0));
    run_vec(103, mk(0,0,0,30'h0,  0,30'h0, 1, 0, 1, 30'h1,  1, 30'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register. It produces IFPC/IFInsn/IFEn for the ID decoder and consumes the decoder's BrTaken/BrAddr redirect. It also honours pipeline-control Stall and Flush/NewPC. It talks to instruction memory over a request/ready handshake and absorbs memory wait states and downstream stalls.

Parameters:
RESET_VECTOR, 30'h0, word address fetched first after reset
NOP_INSN, 32'h0, instruction word driven on IFInsn when IFEn=0

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous reset, active-high
Stall  in  1  ID stalled (load hazard or downstream busy); hold IF/ID register
Flush  in  1  discard pipeline contents; redirect to NewPC
NewPC  in  30  flush/exception target word address
BrTaken  in  1  decoder: instruction in IF/ID is a taken branch/jump
BrAddr  in  30  decoder: branch target word address
InsnReq  out  1  instruction memory request
InsnAddr  out  30  request word address; stable while InsnReq=1 and InsnRdy=0
InsnRdy  in  1  memory response valid; may assert in the same cycle as InsnReq
InsnRdData  in  32  instruction word, valid when InsnRdy=1
IFPC  out  30  PC of instruction in IF/ID
IFInsn  out  32  instruction in IF/ID
IFEn  out  1  IF/ID holds a valid instruction
Busy  out  1  InsnReq & ~InsnRdy; stall request to pipeline control

Behaviour:
- Reset (sync, active-high):
  - PC=RESET_VECTOR, ReqAddr=RESET_VECTOR.
  - state=FETCH.
  - IFPC=0, IFInsn=NOP_INSN, IFEn=0.
  - Skid buffer invalid.
  - Reset overrides every other input.
- Registers:
  - PC: next address to fetch.
  - ReqAddr: drives InsnAddr. Latched from PC when a new request launches; held while a request is outstanding.
  - Skid buffer: SkidPC, SkidInsn.
  - State: FETCH, HOLD, DRAIN.
- FETCH:
  - InsnReq=1, InsnAddr=ReqAddr.
  - Accept = InsnRdy in the same cycle.
  - Accept & ~Stall: IF/ID <= {ReqAddr, InsnRdData, IFEn=1}; PC, ReqAddr <= ReqAddr+1. Back-to-back fetches give 1 instruction/cycle with zero-wait memory.
  - Accept & Stall: IF/ID unchanged; skid <= {ReqAddr, InsnRdData}; goto HOLD.
  - ~InsnRdy: IF/ID unchanged if Stall. Otherwise load a bubble (IFEn=0, IFInsn=NOP_INSN).
- HOLD:
  - InsnReq=0.
  - When Stall=0: IF/ID <= skid with IFEn=1; PC, ReqAddr <= SkidPC+1; goto FETCH.
- DRAIN:
  - Entered when a redirect occurs while a request is outstanding (InsnReq=1, InsnRdy=0).
  - InsnReq stays 1 with the old ReqAddr until InsnRdy. The returned data is discarded.
  - Next cycle: ReqAddr <= PC (the redirect target), goto FETCH.
  - IF/ID holds a bubble throughout.
- Redirect priority: Flush > Stall > BrTaken > sequential.
  - Flush (any state): PC <= NewPC; IF/ID <= bubble; skid invalidated. From HOLD, or FETCH with InsnRdy=1, goto FETCH with ReqAddr <= NewPC. From FETCH with InsnRdy=0, goto DRAIN. Flush overrides Stall.
  - BrTaken & IFEn & ~Stall & ~Flush: PC <= BrAddr. Any instruction accepted this cycle or held in skid is discarded, and IF/ID <= bubble. There is no delay slot. Outstanding request: goto DRAIN. Otherwise ReqAddr <= BrAddr, goto FETCH.
  - BrTaken while Stall=1 is ignored. The decoder re-presents it when the stall releases.
- Arithmetic: PC+1 is 30-bit unsigned and wraps 30'h3FFFFFFF -> 30'h0.
- Simultaneous events:
  - Flush+BrTaken: Flush wins.
  - InsnRdy in DRAIN in the same cycle as a new Flush: discard the data, ReqAddr <= NewPC, goto FETCH.
- Invariants:
  - InsnAddr never changes while InsnReq=1 and InsnRdy=0.
  - IFEn=0 implies IFInsn=NOP_INSN.

Test Plan:
1. Reset, zero-wait memory returning InsnRdData=addr|0xA0000000 -> IFPC 0,1,2,3 on consecutive cycles, IFEn=1 from cycle 2, InsnAddr 0,1,2,...
2. Memory with 2 wait states -> Busy=1 for 2 cycles per fetch, InsnAddr stable, IF/ID bubbles (IFEn=0, IFInsn=0) between valid instructions.
3. Stall=1 for 3 cycles coinciding with response for addr 5 -> IF/ID frozen at addr 4, state HOLD, InsnReq=0. After release, IFPC=5, next InsnAddr=6, no instruction lost or duplicated.
4. BrTaken=1, BrAddr=0x100 while IFPC=7 valid, zero-wait -> the instruction at 8 is discarded (IFEn=0 next cycle), next InsnAddr=0x100, IFPC=0x100 one cycle later.
5. Flush with NewPC=0x40 while a request to 0x12 waits on InsnRdy -> InsnAddr held at 0x12 until InsnRdy, data discarded, then InsnAddr=0x40. Flush+Stall together flushes anyway.
6. PC=30'h3FFFFFFF fetched -> next InsnAddr=0. Reset asserted mid-DRAIN -> next cycle InsnAddr=RESET_VECTOR, IFEn=0.
